// File: rtl/ila_capture_ctrl_pkg.sv
// Shared types and state encoding for the ILA capture controller.
// State codes are shared with any C-side decoder of the state register.
package ila_capture_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_FILL = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  // One-cycle strobes from the FSM into the address/counter datapath.
  typedef struct packed {
    logic clr;
    logic wr;
    logic pre_inc;
    logic trig;
    logic post_inc;
    logic post_clr;
  } addr_ctl_t;

endpackage

// File: rtl/ila_capture_ctrl_if.sv
// Sample-buffer port: write strobe/address out, logical-to-physical readout.
interface ila_capture_ctrl_if #(parameter int BUFFER_W = 10);
  logic                wr_en;
  logic [BUFFER_W-1:0] wr_addr;
  logic [BUFFER_W-1:0] rd_index;
  logic [BUFFER_W-1:0] rd_addr;

  modport master (output wr_en, wr_addr, rd_addr, input rd_index);
  modport slave  (input wr_en, wr_addr, rd_addr, output rd_index);
endinterface

// File: rtl/ila_capture_ctrl_addr.sv
// Write pointer, pre/post sample counters, trigger address latch and
// registered readout translation (module ila_capture_addr).
module ila_capture_addr
  import ila_capture_ctrl_pkg::*;
#(
  parameter int BUFFER_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  addr_ctl_t           ctl,
  input  logic                done_st,
  input  logic [BUFFER_W-1:0] rd_index,
  output logic [BUFFER_W-1:0] wr_addr,
  output logic [BUFFER_W-1:0] pre_cnt,
  output logic [BUFFER_W:0]   post_cnt,
  output logic [BUFFER_W-1:0] trig_addr,
  output logic [BUFFER_W-1:0] rd_addr
);

  localparam logic [BUFFER_W-1:0] ONE   = 1;
  localparam logic [BUFFER_W:0]   ONE_W = 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      rd_addr   <= '0;
    end else begin
      if (ctl.clr) begin
        wr_addr  <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else begin
        if (ctl.wr)      wr_addr <= wr_addr + ONE;
        if (ctl.pre_inc) pre_cnt <= pre_cnt + ONE;
        if (ctl.trig) begin
          trig_addr <= wr_addr;
          post_cnt  <= ONE_W;
        end else if (ctl.post_clr) begin
          post_cnt <= '0;
        end else if (ctl.post_inc) begin
          post_cnt <= post_cnt + ONE_W;
        end
      end
      // Oldest kept sample sits pre_cnt slots before the trigger, mod DEPTH.
      rd_addr <= done_st ? (trig_addr - pre_cnt + rd_index) : rd_index;
    end
  end

endmodule

// File: rtl/ila_capture_ctrl.sv
// ILA capture FSM: pre-trigger ring fill, trigger wait, post-trigger capture.
// Optional trigger-wait timeout when ILA_CAPTURE_CTRL_TIMEOUT_EN is defined.
module ila_capture_ctrl
  import ila_capture_ctrl_pkg::*;
#(
  parameter int BUFFER_W  = 10,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trigger,
  input  logic                 sample_valid,
  input  logic [BUFFER_W-1:0]  pre_samples,
  input  logic [BUFFER_W-1:0]  post_samples,
  ila_capture_ctrl_if.master   bus,
  output logic [BUFFER_W-1:0]  trig_addr,
  output logic [STATE_W-1:0]   state,
  output logic                 busy,
  output logic                 done,
  output logic [BUFFER_W:0]    n_samples
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
  ,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 timed_out
`endif
);

  localparam logic [BUFFER_W-1:0] ONE   = 1;
  localparam logic [BUFFER_W:0]   ONE_W = 1;
  localparam logic [BUFFER_W:0]   DEPTH = {1'b1, {BUFFER_W{1'b0}}};

  logic [STATE_W-1:0]  state_nx;
  addr_ctl_t           ctl;
  logic [BUFFER_W-1:0] pre_reg;
  logic [BUFFER_W:0]   post_eff;
  logic [BUFFER_W:0]   post_req, post_lim, post_arm;
  logic [BUFFER_W-1:0] wr_addr, pre_cnt, rd_addr;
  logic [BUFFER_W:0]   post_cnt;

`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_ONE = 1;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_fire;
`else
  if (TIMEOUT_W > 0) begin : g_no_timeout
  end
`endif

  // Post depth is at least the trigger sample and never overruns the ring.
  always_comb begin
    post_req = {1'b0, post_samples};
    if (post_samples == '0) post_req = ONE_W;
    post_lim = DEPTH - {1'b0, pre_samples};
    post_arm = (post_req > post_lim) ? post_lim : post_req;
  end

  always_comb begin
    state_nx = state;
    ctl      = '0;
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          ctl.clr  = 1'b1;
          state_nx = (pre_samples == '0) ? ST_WAIT : ST_FILL;
        end
      end
      ST_FILL: begin
        if (sample_valid) begin
          ctl.wr      = 1'b1;
          ctl.pre_inc = 1'b1;
          if (pre_cnt + ONE == pre_reg) state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sample_valid) begin
          ctl.wr = 1'b1;
          if (trigger) begin
            ctl.trig = 1'b1;
            state_nx = (post_eff == ONE_W) ? ST_DONE : ST_POST;
          end else begin
            ctl.pre_inc = (pre_cnt != pre_reg);
          end
        end
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
        if (!(sample_valid && trigger) && (timeout_cycles != '0) &&
            (tmo_cnt + TMO_ONE == timeout_cycles)) begin
          tmo_fire     = 1'b1;
          ctl.post_clr = 1'b1;
          state_nx     = ST_DONE;
        end
`endif
      end
      ST_POST: begin
        if (sample_valid) begin
          ctl.wr       = 1'b1;
          ctl.post_inc = 1'b1;
          if (post_cnt + ONE_W == post_eff) state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle write.
    if (abort) begin
      state_nx = ST_IDLE;
      ctl      = '0;
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
      tmo_fire = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pre_reg  <= '0;
      post_eff <= '0;
    end else begin
      state <= state_nx;
      if (ctl.clr) begin
        pre_reg  <= pre_samples;
        post_eff <= post_arm;
      end
    end
  end

`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else if (ctl.clr) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TMO_ONE;
      if (tmo_fire) timed_out <= 1'b1;
    end
  end
`endif

  ila_capture_addr #(.BUFFER_W(BUFFER_W)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl       (ctl),
    .done_st   (state == ST_DONE),
    .rd_index  (bus.rd_index),
    .wr_addr   (wr_addr),
    .pre_cnt   (pre_cnt),
    .post_cnt  (post_cnt),
    .trig_addr (trig_addr),
    .rd_addr   (rd_addr)
  );

  assign bus.wr_en   = ctl.wr;
  assign bus.wr_addr = wr_addr;
  assign bus.rd_addr = rd_addr;
  assign busy        = (state == ST_FILL) || (state == ST_WAIT) || (state == ST_POST);
  assign done        = (state == ST_DONE);
  assign n_samples   = {1'b0, pre_cnt} + post_cnt;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl at BUFFER_W=4; timeout scenario runs
// only when ILA_CAPTURE_CTRL_TIMEOUT_EN is defined.
module tb_ila_capture_ctrl;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, trigger = 1'b0, sample_valid = 1'b0;
  logic [BW-1:0] pre_samples = '0, post_samples = '0;
  logic [BW-1:0] trig_addr;
  logic [2:0]    state;
  logic          busy, done;
  logic [BW:0]   n_samples;
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
  logic [31:0]   timeout_cycles = '0;
  logic          timed_out;
`endif

  int vec = 0;
  int errs = 0;

  ila_capture_ctrl_if #(.BUFFER_W(BW)) bus ();

  ila_capture_ctrl #(.BUFFER_W(BW), .TIMEOUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trigger(trigger),
    .sample_valid(sample_valid), .pre_samples(pre_samples),
    .post_samples(post_samples), .bus(bus), .trig_addr(trig_addr),
    .state(state), .busy(busy), .done(done), .n_samples(n_samples)
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
    , .timeout_cycles(timeout_cycles), .timed_out(timed_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int pre, input int post);
    pre_samples = BW'(pre); post_samples = BW'(post); arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    bus.rd_index = 4'd7; sample_valid = 1'b1;
    tick();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", state); end
    vec++; if (bus.wr_addr !== 4'd0 || trig_addr !== 4'd0 || bus.rd_addr !== 4'd0)
      begin errs++; $display("FAIL reset_addr: got wr=%0d trig=%0d rd=%0d want 0", bus.wr_addr, trig_addr, bus.rd_addr); end
    vec++; if ({busy, done, bus.wr_en} !== 3'b000 || n_samples !== 5'd0)
      begin errs++; $display("FAIL reset_flags: got bdw=%b n=%0d want 000/0", {busy, done, bus.wr_en}, n_samples); end
    rst_n = 1'b1; sample_valid = 1'b0; bus.rd_index = '0;
    tick();
  endtask

  task automatic test_basic();
    int wrs = 1;
    do_arm(4, 4);
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL basic_fill: got %0d want 1", state); end
    sample_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      trigger = (k == 10);
      #1;
      if (k == 10) begin
        vec++; if (bus.wr_en !== 1'b1) begin errs++; $display("FAIL basic_trig_wr: got %b want 1", bus.wr_en); end
      end
      tick();
      if (k == 4) begin
        vec++; if (state !== 3'd2) begin errs++; $display("FAIL basic_wait: got %0d want 2", state); end
      end
    end
    trigger = 1'b0;
    vec++; if (state !== 3'd3) begin errs++; $display("FAIL basic_post: got %0d want 3", state); end
    vec++; if (trig_addr !== 4'd9) begin errs++; $display("FAIL basic_trig_addr: got %0d want 9", trig_addr); end
    for (int c = 0; c < 20 && state !== 3'd4; c++) begin
      if (bus.wr_en === 1'b1) wrs++;
      tick();
    end
    vec++; if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL basic_done: got st=%0d done=%b busy=%b want 4/1/0", state, done, busy); end
    vec++; if (wrs !== 4) begin errs++; $display("FAIL basic_post_writes: got %0d want 4", wrs); end
    vec++; if (n_samples !== 5'd8) begin errs++; $display("FAIL basic_n: got %0d want 8", n_samples); end
    vec++; if (bus.wr_en !== 1'b0) begin errs++; $display("FAIL basic_done_wr: got %b want 0", bus.wr_en); end
    sample_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_index = BW'(i);
      tick();
      vec++; if (bus.rd_addr !== BW'(5 + i))
        begin errs++; $display("FAIL basic_rd[%0d]: got %0d want %0d", i, bus.rd_addr, 5 + i); end
    end
  endtask

  task automatic test_min();
    do_arm(0, 0);
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL min_wait: got %0d want 2", state); end
    sample_valid = 1'b1; trigger = 1'b1;
    #1;
    vec++; if (bus.wr_en !== 1'b1) begin errs++; $display("FAIL min_wr: got %b want 1", bus.wr_en); end
    tick();
    trigger = 1'b0;
    vec++; if (state !== 3'd4 || n_samples !== 5'd1 || trig_addr !== 4'd0)
      begin errs++; $display("FAIL min_done: got st=%0d n=%0d trig=%0d want 4/1/0", state, n_samples, trig_addr); end
    vec++; if (bus.wr_en !== 1'b0) begin errs++; $display("FAIL min_no_wr: got %b want 0", bus.wr_en); end
    sample_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_arm(12, 10);
    pre_samples = '0; post_samples = 4'd1;
    sample_valid = 1'b1;
    repeat (12) tick();
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL wrap_wait: got %0d want 2", state); end
    repeat (6) tick();
    vec++; if (state !== 3'd2 || bus.wr_addr !== 4'd2)
      begin errs++; $display("FAIL wrap_ptr: got st=%0d wr=%0d want 2/2", state, bus.wr_addr); end
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    vec++; if (state !== 3'd3 || trig_addr !== 4'd2)
      begin errs++; $display("FAIL wrap_trig: got st=%0d trig=%0d want 3/2", state, trig_addr); end
    for (int c = 0; c < 20 && state !== 3'd4; c++) tick();
    vec++; if (state !== 3'd4 || n_samples !== 5'd16)
      begin errs++; $display("FAIL wrap_done: got st=%0d n=%0d want 4/16", state, n_samples); end
    sample_valid = 1'b0;
    bus.rd_index = 4'd0; tick();
    vec++; if (bus.rd_addr !== 4'd6) begin errs++; $display("FAIL wrap_rd0: got %0d want 6", bus.rd_addr); end
    bus.rd_index = 4'd15; tick();
    vec++; if (bus.rd_addr !== 4'd5) begin errs++; $display("FAIL wrap_rd15: got %0d want 5", bus.rd_addr); end
  endtask

  task automatic test_ignore();
    do_arm(3, 2);
    sample_valid = 1'b0; trigger = 1'b1;
    #1;
    vec++; if (bus.wr_en !== 1'b0) begin errs++; $display("FAIL ign_wr: got %b want 0", bus.wr_en); end
    tick();
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL ign_fill0: got %0d want 1", state); end
    sample_valid = 1'b1;
    tick();
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL ign_fill1: got %0d want 1", state); end
    trigger = 1'b0;
    repeat (2) tick();
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL ign_wait: got %0d want 2", state); end
    sample_valid = 1'b0; trigger = 1'b1;
    repeat (3) tick();
    vec++; if (state !== 3'd2 || bus.wr_addr !== 4'd3)
      begin errs++; $display("FAIL ign_hold: got st=%0d wr=%0d want 2/3", state, bus.wr_addr); end
    trigger = 1'b0;
  endtask

  task automatic test_abort();
    sample_valid = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    vec++; if (state !== 3'd3) begin errs++; $display("FAIL abort_post: got %0d want 3", state); end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    vec++; if (state !== 3'd0 || bus.wr_en !== 1'b0 || done !== 1'b0)
      begin errs++; $display("FAIL abort_idle: got st=%0d wr=%b done=%b want 0/0/0", state, bus.wr_en, done); end
    vec++; if (n_samples !== 5'd4) begin errs++; $display("FAIL abort_keep: got %0d want 4", n_samples); end
    sample_valid = 1'b0;
    bus.rd_index = 4'd5;
    do_arm(2, 2);
    sample_valid = 1'b1;
    repeat (2) tick();
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL rst_pre_wait: got %0d want 2", state); end
    rst_n = 1'b0;
    #1;
    vec++; if (state !== 3'd0 || bus.wr_addr !== 4'd0 || trig_addr !== 4'd0 || bus.rd_addr !== 4'd0)
      begin errs++; $display("FAIL rst_async: got st=%0d wr=%0d trig=%0d rd=%0d want 0", state, bus.wr_addr, trig_addr, bus.rd_addr); end
    vec++; if ({busy, done, bus.wr_en} !== 3'b000 || n_samples !== 5'd0)
      begin errs++; $display("FAIL rst_flags: got bdw=%b n=%0d want 000/0", {busy, done, bus.wr_en}, n_samples); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vec++; if (state !== 3'd0 || bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd0)
      begin errs++; $display("FAIL rst_release: got st=%0d wr_en=%b wr=%0d want 0/0/0", state, bus.wr_en, bus.wr_addr); end
    vec++; if (bus.rd_addr !== 4'd5) begin errs++; $display("FAIL idle_rd: got %0d want 5", bus.rd_addr); end
    sample_valid = 1'b0;
  endtask

`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cnt = 0;
    timeout_cycles = 32'd20;
    do_arm(1, 1);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL tmo_wait: got %0d want 2", state); end
    while (state === 3'd2 && cnt < 40) begin tick(); cnt++; end
    vec++; if (cnt !== 20 || state !== 3'd4)
      begin errs++; $display("FAIL tmo_cycles: got %0d st=%0d want 20/4", cnt, state); end
    vec++; if (timed_out !== 1'b1 || n_samples !== 5'd1)
      begin errs++; $display("FAIL tmo_flag: got to=%b n=%0d want 1/1", timed_out, n_samples); end
    do_arm(1, 1);
    vec++; if (timed_out !== 1'b0) begin errs++; $display("FAIL tmo_clear: got %b want 0", timed_out); end
    timeout_cycles = '0;
  endtask
`endif

  initial begin
    bus.rd_index = '0;
    test_reset();
    test_basic();
    test_min();
    test_wrap();
    test_ignore();
    test_abort();
`ifdef ILA_CAPTURE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
